lfsr_decrypt: RTL and testbench
===============================

# lfsr_decrypt

Decryption engine for the Lab 4/5 LFSR cipher: the receive-side counterpart of the encryptor that writes `0x5F` preamble bytes XOR LFSR state, followed by message bytes XOR LFSR state, into `dat_mem[64..127]`. The block reads that ciphertext through the `dat_mem` port and recovers the LFSR start state from byte 64. It identifies the feedback taps by testing six fixed candidates in parallel, strips the preamble, and writes the recovered plaintext to `dat_mem[0..MSG_LEN-1]`. It sits in the same top level as `dat_mem` and drives its read/write ports directly.

## Interface
Parameters:
- `ENC_BASE`, default 64: first ciphertext address.
- `ENC_LEN`, default 64: number of ciphertext bytes.
- `MSG_LEN`, default 50: number of plaintext bytes written, starting at address 0.
- `PRE_MIN`, default 7: guaranteed minimum preamble length; bytes `ENC_BASE..ENC_BASE+PRE_MIN-1` are used for tap search.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock.
- `init` input 1: reset, synchronous and active-high.
- `raddr` output 8: dat_mem read address.
- `data_out` input 8: dat_mem read data; combinational from `raddr`.
- `waddr` output 8: dat_mem write address.
- `data_in` output 8: dat_mem write data.
- `write_en` output 1: dat_mem write enable; the write commits at the next `clk` edge.
- `taps_found` output 6: selected tap pattern.
- `err` output 1: decode failed.
- `done` output 1: operation complete; held high until `init`.

## Operation
- LFSR rule, identical to the encryptor: `next(s) = {s[4:0], ^(s & taps)}`. Byte i of the ciphertext is `P_i ^ {2'b00, S(i)}`, where `S(0) = start` and `S(i+1) = next(S(i))`.
- Candidate taps, index 0..5: `6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39`. One LFSR instance per candidate.
- States: `RST`, `LOAD`, `SEARCH`, `SELECT`, `DECODE`, `PAD`, `DONE`, `FAIL`.
- `RST`: active while `init` is high. Next state is `LOAD`.
- `LOAD`: `raddr = ENC_BASE`. Capture `start = data_out[5:0] ^ 6'h1F` and load all six LFSRs with `start`. Set all match flags to 1. If `data_out[7:6] != 2'b01`, go to `FAIL`.
- `SEARCH`: for j = 1..PRE_MIN-1, `raddr = ENC_BASE+j`. Each candidate LFSR advances once, and its flag clears if `data_out != 8'h5F ^ {2'b00, S_k(j)}`.
- `SELECT`: `taps_found` takes the lowest-index candidate whose flag is still 1. If no flag is set, go to `FAIL`. Otherwise reload the selected LFSR with `start` and reset the read index to 0.
- `DECODE`: read `ENC_BASE+i` and compute `d = data_out ^ {2'b00, S(i)}`; the LFSR advances every cycle.
  - While no message byte has been written yet and `d == 8'h5F`, the byte is preamble and nothing is written.
  - Otherwise write `d` to `waddr` = write count, with `write_en = 1`.
  - Go to `DONE` when the write count reaches `MSG_LEN`. Go to `PAD` if i reaches `ENC_LEN` first.
- `PAD`: write `8'h20` to each remaining address up to `MSG_LEN-1`, then go to `DONE`.
- `DONE` / `FAIL`: `done = 1`. In `FAIL`, `err = 1` and nothing has been written. The block stays in this state until `init`.
- Known limitation: plaintext whose first character is `0x5F` is consumed as preamble.
- Address arithmetic is 8-bit. `ENC_BASE + ENC_LEN <= 256` is required and is not checked.

## Timing
- Reset values: `done = 0`, `err = 0`, `write_en = 0`, `taps_found = 0`, `raddr = 0`, `waddr = 0`, `data_in = 0`.
- Exactly one memory read and at most one write per cycle. `write_en` is high only in `DECODE` (message bytes) and `PAD`.
- Let p be the preamble length, capped at `ENC_LEN`. Measured from the first cycle with `init = 0`, `done` rises after exactly `1 + (PRE_MIN-1) + 1 + p + MSG_LEN` cycles. This holds with or without padding, because each pad write replaces one ciphertext read.
- `FAIL` from `LOAD`: `done` rises 1 cycle after `init` falls. `FAIL` from `SELECT`: `done` rises after `PRE_MIN + 1` cycles.
- `init` asserted in any state: at the next edge the block enters `RST`, all outputs return to reset values, and no write occurs in that cycle. Memory contents already written are not undone.
- Simultaneous `init` and a final write: `init` wins and the write is suppressed.

## Test plan
- taps `6'h2D`, start `6'h05`, pre_len 10, 50-character message → `mem[0..49]` equals the plaintext, `taps_found = 2D`, `err = 0`, `done` at cycle 68.
- taps `6'h39`, pre_len 7 (the minimum) → correct plaintext, `taps_found = 39`, `done` at cycle 65.
- pre_len 20, taps `6'h21` → `mem[0..43]` holds the first 44 plaintext characters, `mem[44..49] = 0x20`, `done` at cycle 78.
- start `6'h00`, so all six candidates match → `taps_found = 21` (lowest index), plaintext is correct.
- `mem[64] = 0xDF` (bits [7:6] wrong) → `done` and `err` both high one cycle after `init` falls, with no `write_en` pulse. Separately, ciphertext matching none of the six taps → `err = 1` at cycle 8.
- `init` pulsed for 2 cycles partway through `DECODE` → outputs return to reset values, the decode restarts, and the final memory image and `done` cycle match the first test.

Source files
------------

// File: rtl/lfsr_decrypt_if.sv
// dat_mem read/write port bundle plus decrypt status, shared by lfsr_decrypt and its memory.
interface lfsr_decrypt_if;
    logic [7:0] raddr;
    logic [7:0] data_out;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       write_en;
    logic [5:0] taps_found;
    logic       err;
    logic       done;

    modport master (
        output raddr, waddr, data_in, write_en, taps_found, err, done,
        input  data_out
    );

    modport slave (
        input  raddr, waddr, data_in, write_en, taps_found, err, done,
        output data_out
    );
endinterface

// File: rtl/lfsr_decrypt.sv
// LFSR cipher decryptor: recovers start state and taps from the preamble, then writes plaintext.
// One dat_mem read per cycle, at most one write; done after 8 + preamble + MSG_LEN cycles, no backpressure.
module lfsr_decrypt #(
    parameter int ENC_BASE = 64,
    parameter int ENC_LEN  = 64,
    parameter int MSG_LEN  = 50,
    parameter int PRE_MIN  = 7
) (
    input  logic           clk,
    input  logic           init,
    lfsr_decrypt_if.master mem
);
    typedef enum logic [2:0] {RST, LOAD, SEARCH, SELECT, DECODE, PAD, DONE, FAIL} state_t;

    localparam logic [7:0] BASE     = 8'(ENC_BASE);
    localparam logic [8:0] ELEN     = 9'(ENC_LEN);
    localparam logic [7:0] MLEN     = 8'(MSG_LEN);
    localparam logic [8:0] PLAST    = 9'(PRE_MIN - 1);
    localparam logic [7:0] PREAMBLE = 8'h5F;
    localparam logic [7:0] PAD_CHAR = 8'h20;
    localparam logic [5:0] CAND [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    state_t     state, state_nxt;
    logic [5:0] start, start_nxt;
    logic [5:0] lfsr [6];
    logic [5:0] lfsr_nxt [6];
    logic [5:0] adv [6];
    logic [5:0] match, match_nxt;
    logic [2:0] sel, sel_nxt;
    logic [5:0] taps, taps_nxt;
    logic [8:0] idx, idx_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic [7:0] rd_addr, wr_addr, wr_dat, dec;
    logic       wr_en;

    always_comb begin
        for (int k = 0; k < 6; k++)
            adv[k] = {lfsr[k][4:0], ^(lfsr[k] & CAND[k])};
    end

    always_comb begin
        state_nxt = state;
        start_nxt = start;
        lfsr_nxt  = lfsr;
        match_nxt = match;
        sel_nxt   = sel;
        taps_nxt  = taps;
        idx_nxt   = idx;
        wcnt_nxt  = wcnt;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_dat    = '0;
        wr_en     = 1'b0;
        dec       = mem.data_out ^ {2'b00, lfsr[sel]};
        case (state)
            RST: state_nxt = LOAD;
            LOAD: begin
                rd_addr   = BASE;
                start_nxt = mem.data_out[5:0] ^ 6'h1F;
                for (int k = 0; k < 6; k++)
                    lfsr_nxt[k] = start_nxt;
                match_nxt = '1;
                idx_nxt   = 9'd1;
                if (mem.data_out[7:6] != 2'b01)
                    state_nxt = FAIL;
                else if (PRE_MIN > 1)
                    state_nxt = SEARCH;
                else
                    state_nxt = SELECT;
            end
            SEARCH: begin
                rd_addr = BASE + idx[7:0];
                for (int k = 0; k < 6; k++) begin
                    lfsr_nxt[k] = adv[k];
                    if (mem.data_out != (PREAMBLE ^ {2'b00, adv[k]}))
                        match_nxt[k] = 1'b0;
                end
                idx_nxt = idx + 9'd1;
                if (idx == PLAST)
                    state_nxt = SELECT;
            end
            SELECT: begin
                // Walk downwards so the lowest surviving candidate wins.
                state_nxt = FAIL;
                for (int k = 5; k >= 0; k--) begin
                    if (match[k]) begin
                        sel_nxt   = 3'(k);
                        taps_nxt  = CAND[k];
                        state_nxt = DECODE;
                    end
                end
                for (int k = 0; k < 6; k++)
                    lfsr_nxt[k] = start;
                idx_nxt  = '0;
                wcnt_nxt = '0;
            end
            DECODE: begin
                rd_addr = BASE + idx[7:0];
                for (int k = 0; k < 6; k++)
                    lfsr_nxt[k] = adv[k];
                idx_nxt = idx + 9'd1;
                if (wcnt != 8'd0 || dec != PREAMBLE) begin
                    wr_en    = 1'b1;
                    wr_addr  = wcnt;
                    wr_dat   = dec;
                    wcnt_nxt = wcnt + 8'd1;
                end
                if (wcnt_nxt == MLEN)
                    state_nxt = DONE;
                else if (idx_nxt == ELEN)
                    state_nxt = PAD;
            end
            PAD: begin
                rd_addr  = BASE;
                wr_en    = 1'b1;
                wr_addr  = wcnt;
                wr_dat   = PAD_CHAR;
                wcnt_nxt = wcnt + 8'd1;
                if (wcnt_nxt == MLEN)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            FAIL:    state_nxt = FAIL;
            default: state_nxt = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state <= RST;
            start <= '0;
            lfsr  <= '{default: '0};
            match <= '0;
            sel   <= '0;
            taps  <= '0;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            start <= start_nxt;
            lfsr  <= lfsr_nxt;
            match <= match_nxt;
            sel   <= sel_nxt;
            taps  <= taps_nxt;
            idx   <= idx_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // A reset arriving alongside a write must win, so the enable is gated here.
    assign mem.raddr      = rd_addr;
    assign mem.waddr      = wr_addr;
    assign mem.data_in    = wr_dat;
    assign mem.write_en   = wr_en & ~init;
    assign mem.taps_found = taps;
    assign mem.done       = (state == DONE) || (state == FAIL);
    assign mem.err        = (state == FAIL);
endmodule

// File: tb/tb_lfsr_decrypt.sv
// Randomised and directed bench for lfsr_decrypt against a queue-based decryption model.
module tb_lfsr_decrypt;
    localparam int ENC_BASE = 64;
    localparam int ENC_LEN  = 64;
    localparam int MSG_LEN  = 50;
    localparam int PRE_MIN  = 7;
    localparam logic [5:0] CAND [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    logic clk;
    logic init;
    lfsr_decrypt_if bus();

    lfsr_decrypt #(
        .ENC_BASE(ENC_BASE), .ENC_LEN(ENC_LEN), .MSG_LEN(MSG_LEN), .PRE_MIN(PRE_MIN)
    ) dut (
        .clk (clk),
        .init(init),
        .mem (bus)
    );

    logic [7:0] mem_arr [256];
    logic [7:0] ct [64];
    logic [7:0] msg [64];
    logic [7:0] exp_img [MSG_LEN];
    logic [5:0] exp_taps;
    logic       exp_err;
    int         exp_cyc;
    int         wr_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.data_out = mem_arr[bus.raddr];

    always @(posedge clk) begin
        if (bus.write_en) begin
            mem_arr[bus.waddr] = bus.data_in;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.raddr, bus.waddr, bus.data_in, bus.write_en,
                    bus.taps_found, bus.err, bus.done});
    endfunction

    // Encryptor: preamble bytes then message bytes, each XOR the running LFSR state.
    task automatic gen(input logic [5:0] taps, input logic [5:0] st0, input int pre);
        logic [5:0] s;
        for (int i = 0; i < 64; i++) begin
            msg[i] = 8'(32 + $urandom_range(0, 94));
            if (msg[i] == 8'h5F) msg[i] = 8'h41;
        end
        s = st0;
        for (int i = 0; i < ENC_LEN; i++) begin
            ct[i] = ((i < pre) ? 8'h5F : msg[i - pre]) ^ {2'b00, s};
            s = step(s, taps);
        end
    endtask

    task automatic ref_model();
        logic [5:0] st, s;
        logic [7:0] d;
        logic [7:0] q [$];
        int sel, p;
        bit ok;
        exp_err  = 1'b0;
        exp_taps = '0;
        for (int j = 0; j < MSG_LEN; j++) exp_img[j] = 8'h00;
        if (ct[0][7:6] != 2'b01) begin
            exp_err = 1'b1;
            exp_cyc = 1;
            return;
        end
        st  = ct[0][5:0] ^ 6'h1F;
        sel = -1;
        for (int k = 5; k >= 0; k--) begin
            ok = 1'b1;
            s  = st;
            for (int j = 1; j < PRE_MIN; j++) begin
                s = step(s, CAND[k]);
                if (ct[j] != (8'h5F ^ {2'b00, s})) ok = 1'b0;
            end
            if (ok) sel = k;
        end
        if (sel < 0) begin
            exp_err = 1'b1;
            exp_cyc = PRE_MIN + 1;
            return;
        end
        exp_taps = CAND[sel];
        s = st;
        p = 0;
        for (int i = 0; i < ENC_LEN; i++) begin
            d = ct[i] ^ {2'b00, s};
            s = step(s, CAND[sel]);
            if (q.size() == 0 && d == 8'h5F) p++;
            else q.push_back(d);
        end
        for (int j = 0; j < MSG_LEN; j++) exp_img[j] = (j < q.size()) ? q[j] : 8'h20;
        exp_cyc = 1 + (PRE_MIN - 1) + 1 + p + MSG_LEN;
    endtask

    // cyc counts edges after the one leaving RST; an init pulse restarts the count.
    task automatic run_dut(input int intr_at, input int intr_len, output int cyc);
        int n, wr0;
        bit intr_done;
        n = 0;
        intr_done = 1'b0;
        cyc = -1;
        init = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("rst_outs", outs(), 64'd0);
        init = 1'b0;
        @(posedge clk);
        #1;
        while (cyc < 0 && n < 2000) begin
            if (!intr_done && intr_at > 0 && n == intr_at) begin
                intr_done = 1'b1;
                wr0 = wr_cnt;
                init = 1'b1;
                repeat (intr_len) @(posedge clk);
                #1 chk("intr_outs", outs(), 64'd0);
                chk("intr_nowrite", 64'(wr_cnt), 64'(wr0));
                init = 1'b0;
                @(posedge clk);
                #1 n = 0;
            end else begin
                @(posedge clk);
                #1 n++;
                if (bus.done) cyc = n;
            end
        end
        if (cyc < 0) chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic run_case(input string tag, input logic [5:0] taps, input logic [5:0] st0,
                            input int pre, input int fault, input int intr_at, input int intr_len,
                            input int d_cyc, input logic [5:0] d_taps);
        int cyc, nz;
        gen(taps, st0, pre);
        if (fault == 1) ct[0] = 8'hDF;
        if (fault == 2) ct[1] = ct[1] ^ 8'h02;
        ref_model();
        for (int a = 0; a < 256; a++) mem_arr[a] = 8'h00;
        for (int i = 0; i < ENC_LEN; i++) mem_arr[ENC_BASE + i] = ct[i];
        wr_cnt = 0;
        run_dut(intr_at, intr_len, cyc);
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        chk({tag, "_taps"}, 64'(bus.taps_found), 64'(exp_taps));
        if (d_cyc > 0) begin
            chk({tag, "_cyc_direct"}, 64'(cyc), 64'(d_cyc));
            chk({tag, "_taps_direct"}, 64'(bus.taps_found), 64'(d_taps));
        end
        if (exp_err) chk({tag, "_no_writes"}, 64'(wr_cnt), 64'd0);
        for (int j = 0; j < MSG_LEN; j++)
            chk($sformatf("%s_mem%0d", tag, j), 64'(mem_arr[j]), 64'(exp_img[j]));
        nz = 0;
        for (int j = MSG_LEN; j < ENC_BASE; j++) if (mem_arr[j] != 8'h00) nz++;
        chk({tag, "_tail_untouched"}, 64'(nz), 64'd0);
    endtask

    initial begin
        init = 1'b1;
        wr_cnt = 0;
        run_case("t2d",    6'h2D, 6'h05, 10, 0, 0,  0, 68, 6'h2D);
        run_case("t39",    6'h39, 6'h05,  7, 0, 0,  0, 65, 6'h39);
        run_case("pad",    6'h21, 6'h05, 20, 0, 0,  0, 78, 6'h21);
        run_case("zero",   6'h39, 6'h00, 10, 0, 0,  0, 68, 6'h21);
        run_case("hdr",    6'h2D, 6'h05, 10, 1, 0,  0,  1, 6'h00);
        run_case("notap",  6'h2D, 6'h05, 10, 2, 0,  0,  8, 6'h00);
        run_case("intr",   6'h2D, 6'h05, 10, 0, 30, 2, 68, 6'h2D);
        run_case("lastwr", 6'h2D, 6'h05, 10, 0, 67, 1, 68, 6'h2D);
        for (int r = 0; r < 6; r++)
            run_case($sformatf("rnd%0d", r), CAND[$urandom_range(0, 5)],
                     6'($urandom_range(0, 63)), $urandom_range(7, 24), 0, 0, 0, 0, 6'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
